// File: rtl/sensor_scheduler.sv
// Request scheduler between the command decoder and N_IF sensor interfaces.
// Buffers one request, enforces a re-read gap, runs continuous polling and returns one response per job.
module sensor_scheduler #(
  parameter int N_IF    = 4,
  parameter int MIN_GAP = 100000000,
  parameter int TIMEOUT = 50000000,
  parameter int PERIOD  = 100000000
) (
  input  logic                i_Clock,
  input  logic                i_Rst,
  input  logic                i_req_valid,
  input  logic [7:0]          i_req_addr,
  input  logic [7:0]          i_req_cmd,
  output logic                o_req_ready,
  output logic [N_IF-1:0]     o_En,
  output logic [7:0]          o_request,
  output logic [1:0]          o_cont_mode,
  input  logic [N_IF-1:0]     i_done,
  input  logic [8*N_IF-1:0]   i_data,
  input  logic [6*N_IF-1:0]   i_comandos,
  output logic                o_resp_valid,
  input  logic                i_resp_ready,
  output logic [7:0]          o_resp_addr,
  output logic [7:0]          o_resp_data,
  output logic [5:0]          o_resp_cmd,
  output logic [1:0]          o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // sender holds its fields stable while valid is high and ready is low.
  localparam int          IW       = (N_IF > 1) ? $clog2(N_IF) : 1;
  localparam logic [7:0]  N_IF_B   = 8'(N_IF);
  localparam logic [31:0] GAP_LOAD = 32'(MIN_GAP);
  localparam logic [31:0] PER_LOAD = 32'(PERIOD);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  state_t state, state_d;

  logic        buf_valid;
  logic [7:0]  buf_addr, buf_cmd;
  logic [1:0]  cont_mode;
  logic [7:0]  cont_addr;
  logic        cont_due;
  logic [31:0] period_cnt, gap_cnt, to_cnt;
  logic        job_cont;
  logic [7:0]  cur_addr;
  logic        resp_bad;

  logic [IW-1:0] cur_idx;
  int            cur_int;
  logic          done_sel;
  logic [7:0]    data_sel;
  logic [5:0]    cmd_sel;
  logic [7:0]    job_addr, job_cmd;
  logic          job_pending, go_issue, go_bad;

  function automatic logic [7:0] map_cmd(input logic [7:0] c);
    case (c)
      8'h34:   return 8'h32;
      8'h35:   return 8'h33;
      default: return c;
    endcase
  endfunction

  assign cur_idx  = cur_addr[IW-1:0];
  assign cur_int  = int'(cur_idx);
  assign done_sel = i_done[cur_idx];
  assign data_sel = i_data[cur_int*8 +: 8];
  assign cmd_sel  = i_comandos[cur_int*6 +: 6];

  assign o_req_ready  = !buf_valid;
  assign o_resp_valid = (state == S_RESP);
  assign o_cont_mode  = cont_mode;
  assign o_dbg_state  = state;

  always_comb begin
    state_d     = state;
    go_issue    = 1'b0;
    go_bad      = 1'b0;
    o_En        = '0;
    // A buffered one-shot always takes priority over a due poll.
    job_pending = buf_valid || cont_due;
    job_addr    = buf_valid ? buf_addr : cont_addr;
    job_cmd     = buf_valid ? map_cmd(buf_cmd) : (cont_mode[1] ? 8'h33 : 8'h32);
    case (state)
      S_IDLE: begin
        if (job_pending) begin
          if (job_addr >= N_IF_B) begin
            go_bad  = 1'b1;
            state_d = S_RESP;
          end else if (gap_cnt == '0) begin
            go_issue = 1'b1;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        o_En[cur_idx] = 1'b1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (done_sel || to_cnt == TO_LAST) state_d = S_RESP;
      end
      S_RESP: begin
        if (i_resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state       <= S_IDLE;
      buf_valid   <= 1'b0;
      buf_addr    <= '0;
      buf_cmd     <= '0;
      cont_mode   <= '0;
      cont_addr   <= '0;
      cont_due    <= 1'b0;
      period_cnt  <= '0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
      job_cont    <= 1'b0;
      cur_addr    <= '0;
      resp_bad    <= 1'b0;
      o_request   <= '0;
      o_resp_addr <= '0;
      o_resp_data <= '0;
      o_resp_cmd  <= '0;
    end else begin
      state <= state_d;
      if (i_req_valid && !buf_valid) begin
        buf_valid <= 1'b1;
        buf_addr  <= i_req_addr;
        buf_cmd   <= i_req_cmd;
      end
      if (gap_cnt != '0) gap_cnt <= gap_cnt - 32'd1;
      if (state == S_ISSUE) begin
        to_cnt <= '0;
        if (job_cont) cont_due <= 1'b0;
      end
      if (state == S_WAIT) begin
        to_cnt <= to_cnt + 32'd1;
        if (done_sel) begin
          o_resp_addr <= cur_addr;
          o_resp_data <= data_sel;
          o_resp_cmd  <= cmd_sel;
          resp_bad    <= 1'b0;
        end else if (to_cnt == TO_LAST) begin
          o_resp_addr <= cur_addr;
          o_resp_data <= 8'h82;
          o_resp_cmd  <= 6'b000001;
          resp_bad    <= 1'b0;
        end
      end
      if (state == S_RESP && i_resp_ready && !resp_bad) gap_cnt <= GAP_LOAD;
      // Sticky due flag: a missed period is not counted twice.
      if (cont_mode != 2'b00) begin
        if (period_cnt == '0) begin
          cont_due   <= 1'b1;
          period_cnt <= PER_LOAD;
        end else begin
          period_cnt <= period_cnt - 32'd1;
        end
      end
      if (go_issue) begin
        cur_addr  <= job_addr;
        o_request <= job_cmd;
        job_cont  <= !buf_valid;
      end
      if (go_bad) begin
        o_resp_addr <= job_addr;
        o_resp_data <= 8'h81;
        o_resp_cmd  <= 6'b000001;
        resp_bad    <= 1'b1;
        if (!buf_valid) cont_due <= 1'b0;
      end
      if ((go_issue || go_bad) && buf_valid) begin
        buf_valid <= 1'b0;
        case (buf_cmd)
          8'h34, 8'h35: begin
            cont_mode  <= (buf_cmd == 8'h34) ? 2'b01 : 2'b10;
            cont_addr  <= buf_addr;
            period_cnt <= PER_LOAD;
            cont_due   <= 1'b0;
          end
          8'h36, 8'h37: begin
            cont_mode <= 2'b00;
            cont_due  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sensor_scheduler.sv
// Self-checking bench for sensor_scheduler: scoreboarded responses, enable log, per-scenario tasks.
module tb_sensor_scheduler;
  localparam int N_IF = 2, MIN_GAP = 20, TIMEOUT = 50, PERIOD = 200;

  logic        i_Clock = 1'b0;
  logic        i_Rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic [7:0]  i_req_addr = '0, i_req_cmd = '0;
  logic        o_req_ready;
  logic [1:0]  o_En;
  logic [7:0]  o_request;
  logic [1:0]  o_cont_mode;
  logic [1:0]  i_done = '0;
  logic [15:0] i_data = {8'h5A, 8'h19};
  logic [11:0] i_comandos = {6'b010000, 6'b001000};
  logic        o_resp_valid;
  logic        i_resp_ready = 1'b1;
  logic [7:0]  o_resp_addr, o_resp_data;
  logic [5:0]  o_resp_cmd;
  logic [1:0]  o_dbg_state;

  sensor_scheduler #(.N_IF(N_IF), .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT), .PERIOD(PERIOD)) dut (
    .i_Clock(i_Clock), .i_Rst(i_Rst), .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .i_req_cmd(i_req_cmd), .o_req_ready(o_req_ready), .o_En(o_En), .o_request(o_request),
    .o_cont_mode(o_cont_mode), .i_done(i_done), .i_data(i_data), .i_comandos(i_comandos),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready), .o_resp_addr(o_resp_addr),
    .o_resp_data(o_resp_data), .o_resp_cmd(o_resp_cmd), .o_dbg_state(o_dbg_state)
  );

  // clock / reset block
  always #5 i_Clock = ~i_Clock;
  int cyc = 0;
  always @(posedge i_Clock) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [21:0] exp_q[$];
  logic [9:0]  en_log[$];
  int          en_gap_q[$];
  int last_hs_cyc = 0, last_en_cyc = 0, rise_cyc = 0, done_cyc = 0, acc_cyc = 0;
  logic prev_valid = 1'b0;
  logic [1:0] done_mask = 2'b01;

  // scoreboard / monitor
  always @(negedge i_Clock) begin
    if (o_resp_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = o_resp_valid;
    if (o_En != '0) begin
      en_log.push_back({o_En, o_request});
      en_gap_q.push_back(cyc - last_hs_cyc);
      last_en_cyc = cyc;
    end
    if (!i_Rst && o_resp_valid && i_resp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got %h_%h_%b, expected none", o_resp_addr, o_resp_data, o_resp_cmd);
      end else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        if ({o_resp_addr, o_resp_data, o_resp_cmd} !== e) begin
          errors++;
          $display("FAIL resp_fields: got %h_%h_%b, expected %h_%h_%b",
                   o_resp_addr, o_resp_data, o_resp_cmd, e[21:14], e[13:6], e[5:0]);
        end
      end
      last_hs_cyc = cyc;
    end
  end

  // interface model: done pulse 5 cycles after enable on slots in done_mask
  initial begin
    forever begin
      @(negedge i_Clock);
      if (o_En != '0 && !i_Rst) begin
        int s;
        s = o_En[1] ? 1 : 0;
        if (done_mask[s]) begin
          repeat (5) @(posedge i_Clock);
          #1;
          if (!i_Rst) begin
            i_done[s] = 1'b1;
            done_cyc = cyc;
          end
          @(posedge i_Clock);
          #1 i_done = '0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] en_at(int i);
    if (i < en_log.size()) return en_log[i];
    return '1;
  endfunction

  // driver tasks
  task automatic wait_cycles(int n);
    repeat (n) @(posedge i_Clock);
    #1;
  endtask

  task automatic send_req(logic [7:0] addr, logic [7:0] cmd);
    bit ok;
    ok = 0;
    i_req_addr = addr;
    i_req_cmd = cmd;
    i_req_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge i_Clock);
      if (o_req_ready) begin
        acc_cyc = cyc;
        ok = 1;
        break;
      end
    end
    @(posedge i_Clock);
    #1 i_req_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_accept: got no acceptance of %h to addr %0d, expected acceptance", cmd, addr);
    end
  endtask

  task automatic wait_drain(int max);
    bit ok;
    ok = 0;
    for (int k = 0; k < max; k++) begin
      @(negedge i_Clock);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    @(posedge i_Clock);
    #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL resp_drain: got %0d pending responses, expected 0", exp_q.size());
    end
  endtask

  task automatic wait_en(int n, int max);
    bit ok;
    ok = 0;
    for (int k = 0; k < max; k++) begin
      @(negedge i_Clock);
      if (en_log.size() >= n) begin
        ok = 1;
        break;
      end
    end
    @(posedge i_Clock);
    #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL en_wait: got %0d enables, expected %0d", en_log.size(), n);
    end
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    wait_cycles(3);
    @(negedge i_Clock);
    checks++;
    if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", o_req_ready); end
    checks++;
    if ({o_En, o_request, o_cont_mode, o_resp_valid} !== 13'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got en=%b req=%h mode=%b valid=%b, expected zeros", o_En, o_request, o_cont_mode, o_resp_valid);
    end
    checks++;
    if ({o_resp_addr, o_resp_data, o_resp_cmd} !== 22'd0) begin
      errors++;
      $display("FAIL reset_resp: got %h_%h_%b, expected zeros", o_resp_addr, o_resp_data, o_resp_cmd);
    end
    @(posedge i_Clock);
    #1 i_Rst = 1'b0;
  endtask

  task automatic test_done();
    en_log.delete();
    exp_q.push_back({8'd0, 8'h19, 6'b001000});
    send_req(8'd0, 8'h32);
    wait_drain(100);
    checks++;
    if (en_log.size() !== 1 || en_at(0) !== {2'b01, 8'h32}) begin
      errors++;
      $display("FAIL done_enable: got %0d enables first=%h, expected 1 of %h", en_log.size(), en_at(0), {2'b01, 8'h32});
    end
    checks++;
    if (last_en_cyc - acc_cyc !== 2) begin
      errors++;
      $display("FAIL done_latency_en: got %0d, expected 2", last_en_cyc - acc_cyc);
    end
    checks++;
    if (rise_cyc - done_cyc !== 1) begin
      errors++;
      $display("FAIL done_latency_resp: got %0d, expected 1", rise_cyc - done_cyc);
    end
  endtask

  task automatic test_timeout();
    en_log.delete();
    exp_q.push_back({8'd1, 8'h82, 6'b000001});
    send_req(8'd1, 8'h33);
    wait_drain(300);
    checks++;
    if (en_log.size() !== 1 || en_at(0) !== {2'b10, 8'h33}) begin
      errors++;
      $display("FAIL timeout_enable: got %0d enables first=%h, expected 1 of %h", en_log.size(), en_at(0), {2'b10, 8'h33});
    end
    checks++;
    if (rise_cyc - last_en_cyc < 50 || rise_cyc - last_en_cyc > 52) begin
      errors++;
      $display("FAIL timeout_delay: got %0d, expected 50..52", rise_cyc - last_en_cyc);
    end
  endtask

  task automatic test_bad_addr();
    en_log.delete();
    // gap from the previous response is still running here
    exp_q.push_back({8'd5, 8'h81, 6'b000001});
    send_req(8'd5, 8'h31);
    wait_drain(20);
    checks++;
    if (rise_cyc - acc_cyc > 3) begin
      errors++;
      $display("FAIL bad_addr_latency: got %0d, expected <=3", rise_cyc - acc_cyc);
    end
    wait_cycles(25);
    exp_q.push_back({8'd5, 8'h81, 6'b000001});
    send_req(8'd5, 8'h31);
    wait_drain(20);
    exp_q.push_back({8'd0, 8'h19, 6'b001000});
    send_req(8'd0, 8'h31);
    wait_drain(100);
    checks++;
    if (last_en_cyc - acc_cyc !== 2) begin
      errors++;
      $display("FAIL bad_addr_no_gap: got %0d, expected 2", last_en_cyc - acc_cyc);
    end
    checks++;
    if (en_log.size() !== 1) begin
      errors++;
      $display("FAIL bad_addr_enables: got %0d, expected 1", en_log.size());
    end
  endtask

  task automatic test_back_to_back();
    en_log.delete();
    en_gap_q.delete();
    exp_q.push_back({8'd0, 8'h19, 6'b001000});
    exp_q.push_back({8'd0, 8'h19, 6'b001000});
    send_req(8'd0, 8'h32);
    i_req_addr = 8'd0;
    i_req_cmd = 8'h33;
    i_req_valid = 1'b1;
    @(negedge i_Clock);
    checks++;
    if (o_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %b, expected 0", o_req_ready); end
    send_req(8'd0, 8'h33);
    wait_drain(300);
    checks++;
    if (en_gap_q.size() !== 2) begin
      errors++;
      $display("FAIL b2b_enables: got %0d, expected 2", en_gap_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (en_gap_q[i] < MIN_GAP) begin
          errors++;
          $display("FAIL b2b_gap: got %0d, expected >=%0d", en_gap_q[i], MIN_GAP);
        end
      end
    end
  endtask

  task automatic test_cont();
    int e0, e1, w;
    en_log.delete();
    exp_q.push_back({8'd0, 8'h19, 6'b001000});
    send_req(8'd0, 8'h34);
    wait_drain(200);
    checks++;
    if (o_cont_mode !== 2'b01) begin errors++; $display("FAIL cont_mode_on: got %b, expected 01", o_cont_mode); end
    checks++;
    if (en_at(0) !== {2'b01, 8'h32}) begin errors++; $display("FAIL cont_first: got %h, expected %h", en_at(0), {2'b01, 8'h32}); end
    e0 = last_en_cyc;
    exp_q.push_back({8'd0, 8'h19, 6'b001000});
    wait_en(2, 400);
    e1 = last_en_cyc;
    checks++;
    if (e1 - e0 < 195 || e1 - e0 > 210) begin
      errors++;
      $display("FAIL cont_period: got %0d, expected 195..210", e1 - e0);
    end
    checks++;
    if (en_at(1) !== {2'b01, 8'h32}) begin errors++; $display("FAIL cont_poll: got %h, expected %h", en_at(1), {2'b01, 8'h32}); end
    wait_drain(100);
    // hold slot 1 busy across the next poll so a one-shot and the poll are both pending
    w = e1 + 170 - cyc;
    if (w > 0) wait_cycles(w);
    exp_q.push_back({8'd1, 8'h82, 6'b000001});
    send_req(8'd1, 8'h31);
    wait_cycles(10);
    exp_q.push_back({8'd1, 8'h82, 6'b000001});
    exp_q.push_back({8'd0, 8'h19, 6'b001000});
    send_req(8'd1, 8'h33);
    wait_drain(600);
    checks++;
    if ({en_at(2), en_at(3), en_at(4)} !== {2'b10, 8'h31, 2'b10, 8'h33, 2'b01, 8'h32}) begin
      errors++;
      $display("FAIL cont_priority: got %h %h %h, expected 231 233 132", en_at(2), en_at(3), en_at(4));
    end
    exp_q.push_back({8'd0, 8'h19, 6'b001000});
    send_req(8'd0, 8'h36);
    wait_drain(200);
    checks++;
    if (o_cont_mode !== 2'b00 || en_at(5) !== {2'b01, 8'h36}) begin
      errors++;
      $display("FAIL cont_off: got mode=%b en=%h, expected 00 and %h", o_cont_mode, en_at(5), {2'b01, 8'h36});
    end
    en_log.delete();
    wait_cycles(450);
    checks++;
    if (en_log.size() !== 0) begin errors++; $display("FAIL cont_stopped: got %0d enables, expected 0", en_log.size()); end
  endtask

  task automatic test_stall_and_reset();
    logic [21:0] snap;
    bit ok, stable;
    i_resp_ready = 1'b0;
    exp_q.push_back({8'd0, 8'h19, 6'b001000});
    send_req(8'd0, 8'h31);
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge i_Clock);
      if (o_resp_valid) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_valid: got no response, expected one"); end
    snap = {o_resp_addr, o_resp_data, o_resp_cmd};
    stable = 1;
    repeat (30) begin
      @(negedge i_Clock);
      if (!o_resp_valid || {o_resp_addr, o_resp_data, o_resp_cmd} !== snap) stable = 0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL stall_stable: got changing fields, expected %h held", snap); end
    @(posedge i_Clock);
    #1 i_resp_ready = 1'b1;
    wait_drain(10);
    done_mask = 2'b00;
    en_log.delete();
    send_req(8'd0, 8'h32);
    wait_en(1, 100);
    wait_cycles(3);
    i_Rst = 1'b1;
    wait_cycles(1);
    @(negedge i_Clock);
    checks++;
    if ({o_req_ready, o_En, o_request, o_cont_mode, o_resp_valid} !== 14'b1_00_00000000_00_0) begin
      errors++;
      $display("FAIL midjob_reset_ctrl: got ready=%b en=%b req=%h mode=%b valid=%b, expected 1 and zeros",
               o_req_ready, o_En, o_request, o_cont_mode, o_resp_valid);
    end
    checks++;
    if ({o_resp_addr, o_resp_data, o_resp_cmd} !== 22'd0) begin
      errors++;
      $display("FAIL midjob_reset_resp: got %h_%h_%b, expected zeros", o_resp_addr, o_resp_data, o_resp_cmd);
    end
    @(posedge i_Clock);
    #1 i_Rst = 1'b0;
    wait_cycles(100);
    checks++;
    if (o_resp_valid !== 1'b0 || en_log.size() !== 1) begin
      errors++;
      $display("FAIL midjob_dropped: got valid=%b enables=%0d, expected 0 and 1", o_resp_valid, en_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_done();
    test_timeout();
    test_bad_addr();
    test_back_to_back();
    test_cont();
    test_stall_and_reset();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL final_queue: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
